fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the instruction memory (IM). Owns the PC and drives the
//  IM address and read enable. IM returns a word while clk is low. This block captures that word into the
//  IF/ID register on the next rising edge. Handles stall, branch redirect/flush and halt detection.

---
 rtl/cpu_defs_pkg.sv | 8 +
 rtl/fetch_unit_if.sv | 9 +
 rtl/fetch_perf_cnt.sv | 10 +
 rtl/fetch_unit.sv | 66 ++++++
 tb/tb_fetch_unit.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared widths, reset PC, halt opcode and fetch FSM state encoding.
package cpu_defs;
    localparam int ADDR_W = 16;
    localparam int INSTR_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
    localparam logic [3:0] HALT_OP = 4'hF;
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALTED = 2'b10} fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read port between the fetch stage (master) and the IM (slave).
interface fetch_unit_if;
    import cpu_defs::*;
    logic [ADDR_W-1:0] im_addr;
    logic im_rd_en;
    logic [INSTR_W-1:0] im_instr;
    modport master(output im_addr, im_rd_en, input im_instr);
    modport slave(input im_addr, im_rd_en, output im_instr);
endinterface

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: 16-bit event counter that saturates at all-ones.
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] cnt
);
    always_ff @(posedge clk)
        cnt <= !rst_n ? 16'h0000 : (en && cnt != 16'hFFFF) ? cnt + 16'h0001 : cnt;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, IM read port and IF/ID register with stall, branch flush and halt.
// Define FETCH_PERF_EN to add saturating fetch/bubble performance counters.
module fetch_unit
    import cpu_defs::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_unit_if.master         im,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [ADDR_W-1:0]    branch_tgt,
    output logic [INSTR_W-1:0]   if_instr,
    output logic [ADDR_W-1:0]    if_pc,
    output logic                 if_valid,
    output logic                 halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]          perf_fetch_cnt,
    output logic [15:0]          perf_bubble_cnt
`endif
);
    fetch_state_t state_q, state_d;
    logic [ADDR_W-1:0] pc;
    logic run, capture, is_halt;

    assign run = state_q == RUN;
    assign capture = run && !branch_taken && !stall;
    assign is_halt = im.im_instr[INSTR_W-1 -: 4] == HALT_OP;

    always_ff @(posedge clk)
        state_q <= !rst_n ? IDLE : state_d;

    always_comb
        state_d = state_q == IDLE ? RUN :
                  state_q == RUN ? ((capture && is_halt) ? HALTED : RUN) :
                  state_q == HALTED ? (branch_taken ? RUN : HALTED) : IDLE;

    assign im.im_addr = pc;
    assign im.im_rd_en = run;
    assign halted = state_q == HALTED;

    // Branch outranks stall in both RUN and HALTED; IDLE ignores every input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            if_instr <= '0;
            if_pc <= '0;
            if_valid <= 1'b0;
        end else if ((run || halted) && branch_taken) begin
            pc <= branch_tgt;
            if_valid <= 1'b0;
        end else if (capture) begin
            if_instr <= im.im_instr;
            if_pc <= pc;
            if_valid <= 1'b1;
            pc <= pc + ADDR_W'(1);
        end else if (halted && !stall) begin
            if_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    fetch_perf_cnt u_fetch_cnt (.clk(clk), .rst_n(rst_n), .en(capture), .cnt(perf_fetch_cnt));
    fetch_perf_cnt u_bubble_cnt (.clk(clk), .rst_n(rst_n), .en(run && (stall || branch_taken)), .cnt(perf_bubble_cnt));
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven check of fetch_unit against a negative-phase IM model plus reset/halt sequences.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n, stall, branch_taken;
    logic [15:0] branch_tgt, if_instr, if_pc;
    logic if_valid, halted;
    int errors = 0;
    int checks = 0;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .im(bus.master), .stall(stall),
        .branch_taken(branch_taken), .branch_tgt(branch_tgt),
        .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid), .halted(halted)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] im_word(input logic [15:0] a);
        return a == 16'd5 ? 16'hF000 : {4'h1, a[11:0]};
    endfunction

    // IM drives its word during the low phase so it is stable at the next rising edge.
    always @(negedge clk)
        if (bus.im_rd_en) bus.im_instr <= im_word(bus.im_addr);

    typedef struct {
        logic rst_n, stall, br;
        logic [15:0] tgt;
        logic v, rd, h;
        logic [15:0] instr, pc, addr;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic r, s, b, input logic [15:0] t, input logic v, rd, h,
                       input logic [15:0] ins, p, a);
        vec_t x;
        x = '{r, s, b, t, v, rd, h, ins, p, a};
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, s, b, input logic [15:0] t);
        rst_n = r; stall = s; branch_taken = b; branch_tgt = t;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " valid"}, 32'(if_valid), 0);
        chk({tag, " instr"}, 32'(if_instr), 0);
        chk({tag, " if_pc"}, 32'(if_pc), 0);
        chk({tag, " halted"}, 32'(halted), 0);
        chk({tag, " rd_en"}, 32'(bus.im_rd_en), 0);
        chk({tag, " addr"}, 32'(bus.im_addr), 0);
    endtask

    initial begin
        //   rst s  b  tgt      v  rd h  instr    if_pc    addr
        add(0, 0, 0, 16'h0,  0, 0, 0, 16'h0,    16'h0,    16'h0);
        add(0, 0, 0, 16'h0,  0, 0, 0, 16'h0,    16'h0,    16'h0);
        add(1, 0, 0, 16'h0,  0, 1, 0, 16'h0,    16'h0,    16'h0);
        add(1, 0, 0, 16'h0,  1, 1, 0, 16'h1000, 16'h0,    16'h1);
        add(1, 0, 0, 16'h0,  1, 1, 0, 16'h1001, 16'h1,    16'h2);
        add(1, 1, 0, 16'h0,  1, 1, 0, 16'h1001, 16'h1,    16'h2);
        add(1, 1, 0, 16'h0,  1, 1, 0, 16'h1001, 16'h1,    16'h2);
        add(1, 1, 0, 16'h0,  1, 1, 0, 16'h1001, 16'h1,    16'h2);
        add(1, 0, 0, 16'h0,  1, 1, 0, 16'h1002, 16'h2,    16'h3);
        add(1, 1, 1, 16'h40, 0, 1, 0, 16'h1002, 16'h2,    16'h40);
        add(1, 0, 0, 16'h0,  1, 1, 0, 16'h1040, 16'h40,   16'h41);
        add(1, 0, 1, 16'h3,  0, 1, 0, 16'h1040, 16'h40,   16'h3);
        add(1, 0, 0, 16'h0,  1, 1, 0, 16'h1003, 16'h3,    16'h4);
        add(1, 0, 0, 16'h0,  1, 1, 0, 16'h1004, 16'h4,    16'h5);
        add(1, 0, 0, 16'h0,  1, 0, 1, 16'hF000, 16'h5,    16'h6);
        add(1, 0, 0, 16'h0,  0, 0, 1, 16'hF000, 16'h5,    16'h6);
        add(1, 0, 0, 16'h0,  0, 0, 1, 16'hF000, 16'h5,    16'h6);
        add(1, 0, 1, 16'h10, 0, 1, 0, 16'hF000, 16'h5,    16'h10);
        add(1, 0, 0, 16'h0,  1, 1, 0, 16'h1010, 16'h10,   16'h11);
        add(1, 0, 1, 16'hFFFE, 0, 1, 0, 16'h1010, 16'h10, 16'hFFFE);
        add(1, 0, 0, 16'h0,  1, 1, 0, 16'h1FFE, 16'hFFFE, 16'hFFFF);
        add(1, 0, 0, 16'h0,  1, 1, 0, 16'h1FFF, 16'hFFFF, 16'h0);
        add(1, 0, 0, 16'h0,  1, 1, 0, 16'h1000, 16'h0,    16'h1);
        add(1, 0, 1, 16'h5,  0, 1, 0, 16'h1000, 16'h0,    16'h5);
        add(1, 0, 0, 16'h0,  1, 0, 1, 16'hF000, 16'h5,    16'h6);
        add(1, 1, 0, 16'h0,  1, 0, 1, 16'hF000, 16'h5,    16'h6);
        add(1, 0, 0, 16'h0,  0, 0, 1, 16'hF000, 16'h5,    16'h6);
        add(1, 1, 1, 16'h20, 0, 1, 0, 16'hF000, 16'h5,    16'h20);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].stall, vecs[i].br, vecs[i].tgt);
            chk($sformatf("v%0d valid", i), 32'(if_valid), 32'(vecs[i].v));
            chk($sformatf("v%0d rd_en", i), 32'(bus.im_rd_en), 32'(vecs[i].rd));
            chk($sformatf("v%0d halted", i), 32'(halted), 32'(vecs[i].h));
            chk($sformatf("v%0d instr", i), 32'(if_instr), 32'(vecs[i].instr));
            chk($sformatf("v%0d if_pc", i), 32'(if_pc), 32'(vecs[i].pc));
            chk($sformatf("v%0d addr", i), 32'(bus.im_addr), 32'(vecs[i].addr));
        end

        // Reset while halted.
        step(1, 0, 1, 16'h5);
        step(1, 0, 0, 16'h0);
        chk("pre-reset halted", 32'(halted), 1);
        step(0, 0, 0, 16'h0);
        chk_reset("rst-halt");

        // Branch during IDLE is ignored, then reset mid-stall.
        step(1, 0, 1, 16'h77);
        chk("idle br addr", 32'(bus.im_addr), 0);
        chk("idle br rd_en", 32'(bus.im_rd_en), 1);
        step(1, 0, 0, 16'h0);
        chk("post-idle instr", 32'(if_instr), 32'h1000);
        chk("post-idle valid", 32'(if_valid), 1);
        step(1, 1, 0, 16'h0);
        step(0, 1, 0, 16'h0);
        chk_reset("rst-stall");

`ifdef FETCH_PERF_EN
        chk("perf fetch rst", 32'(perf_fetch_cnt), 0);
        chk("perf bubble rst", 32'(perf_bubble_cnt), 0);
        step(1, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 16'h0);
        chk("perf fetch 3", 32'(perf_fetch_cnt), 3);
        chk("perf bubble 0", 32'(perf_bubble_cnt), 0);
        step(1, 0, 1, 16'h100);
        chk("perf bubble br", 32'(perf_bubble_cnt), 1);
        for (int i = 0; i < 65540; i++) step(1, 1, 0, 16'h0);
        chk("perf bubble sat", 32'(perf_bubble_cnt), 32'hFFFF);
        chk("perf fetch hold", 32'(perf_fetch_cnt), 3);
        step(0, 0, 0, 16'h0);
        chk("perf bubble clr", 32'(perf_bubble_cnt), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
